kmap_lut_seq: RTL and testbench

Parametrised, registered, programmable truth-table engine and the sequential successor of the fixed 4-input K-map function blocks. An N_IN-input, N_OUT-output table is loaded serially, then evaluated on demand or swept exhaustively over all 2^N_IN input codes. A sweep also counts the minterms of output bit 0. Used as a self-checking on-chip replacement for exhaustive combinational testbench loops.

---
 rtl/kmap_pkg.sv | 20 ++
 rtl/kmap_cfg_shifter.sv | 66 ++++++
 rtl/kmap_lut_seq.sv | 148 ++++++++++++++
 tb/tb_kmap_lut_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmap_pkg.sv
// Shared types and helpers for the programmable truth-table engine.
// Holds the sweep FSM encoding, table sizing and the cleared-table constant.
package kmap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    FIN
  } state_t;

  // Largest table: 2**8 entries of 8 outputs.
  localparam int unsigned MAX_TBL_BITS = 2048;

  localparam logic [MAX_TBL_BITS-1:0] DEFAULT_TBL = '0;

  function automatic int unsigned tbl_bits(input int unsigned n_in, input int unsigned n_out);
    return (32'd1 << n_in) * n_out;
  endfunction

endpackage

// File: rtl/kmap_cfg_shifter.sv
// Serial loader for the truth table: LSB-first shadow register, bit counter and commit pulse.
// The shadow is only handed to the active table once every bit has arrived.
module kmap_cfg_shifter
  import kmap_pkg::*;
#(
  parameter int unsigned TBL_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                cfg_valid,
  input  logic                cfg_bit,
  output logic                cfg_ready,
  output logic                commit,
  output logic                cfg_done,
  output logic [TBL_BITS-1:0] shadow
);

  localparam int unsigned CW = (TBL_BITS > 1) ? $clog2(TBL_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TBL_BITS - 1);

  logic [TBL_BITS-1:0] shadow_q, shadow_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                full_q, full_d;
  logic                done_q;
  logic                accept;

  assign cfg_ready = enable;
  assign accept    = cfg_valid && enable;

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    full_d   = 1'b0;
    if (accept) begin
      shadow_d[cnt_q] = cfg_bit;
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        full_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Commit happens one edge after the last bit; the done pulse follows the commit
  // so it coincides with the new table being visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= DEFAULT_TBL[TBL_BITS-1:0];
      cnt_q    <= '0;
      full_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      done_q   <= full_q;
    end
  end

  assign commit   = full_q;
  assign cfg_done = done_q;
  assign shadow   = shadow_q;

endmodule

// File: rtl/kmap_lut_seq.sv
// Registered programmable truth-table engine with on-demand evaluation and exhaustive sweep.
// A sweep issues every input code once and counts the codes whose output bit 0 is set.
module kmap_lut_seq
  import kmap_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_ready,
  output logic             cfg_done,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_vec,
  output logic             in_ready,
  output logic             out_valid,
  output logic [N_OUT-1:0] out_vec,
  output logic [N_IN-1:0]  out_idx,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [N_IN:0]    sweep_count
);

  localparam int unsigned DEPTH    = 2 ** N_IN;
  localparam int unsigned TBL_BITS = tbl_bits(N_IN, N_OUT);
  localparam int unsigned CNT_W    = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(DEPTH - 1);

  state_t state_q, state_d;

  logic [TBL_BITS-1:0] tbl_q;
  logic [TBL_BITS-1:0] shadow;
  logic                commit;
  logic                idle;

  logic [N_IN-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic [N_OUT-1:0] ovec_q, ovec_d;
  logic [N_IN-1:0]  oidx_q, oidx_d;
  logic             sw_out_q, sw_out_d;
  logic             done_q, done_d;

  function automatic logic [N_OUT-1:0] lookup(input logic [TBL_BITS-1:0] t,
                                               input logic [N_IN-1:0]     code);
    return t[int'(code) * N_OUT +: N_OUT];
  endfunction

  assign idle = (state_q == IDLE);

  kmap_cfg_shifter #(
    .TBL_BITS (TBL_BITS)
  ) u_cfg_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (idle),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .commit    (commit),
    .cfg_done  (cfg_done),
    .shadow    (shadow)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ov_d     = 1'b0;
    ovec_d   = ovec_q;
    oidx_d   = oidx_q;
    sw_out_d = 1'b0;
    done_d   = 1'b0;

    // Count each sweep result in the cycle it is presented.
    if (ov_q && sw_out_q && ovec_q[0]) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          ov_d   = 1'b1;
          oidx_d = in_vec;
          ovec_d = lookup(tbl_q, in_vec);
        end
        if (sweep_start) begin
          state_d = SWEEP;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        ov_d     = 1'b1;
        sw_out_d = 1'b1;
        oidx_d   = idx_q;
        ovec_d   = lookup(tbl_q, idx_q);
        idx_d    = idx_q + N_IN'(1);
        if (idx_q == LAST_IDX) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tbl_q    <= DEFAULT_TBL[TBL_BITS-1:0];
      idx_q    <= '0;
      cnt_q    <= '0;
      ov_q     <= 1'b0;
      ovec_q   <= '0;
      oidx_q   <= '0;
      sw_out_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      ov_q     <= ov_d;
      ovec_q   <= ovec_d;
      oidx_q   <= oidx_d;
      sw_out_q <= sw_out_d;
      done_q   <= done_d;
      if (commit) begin
        tbl_q <= shadow;
      end
    end
  end

  assign in_ready    = idle;
  assign sweep_busy  = !idle;
  assign sweep_done  = done_q;
  assign sweep_count = cnt_q;
  assign out_valid   = ov_q;
  assign out_vec     = ovec_q;
  assign out_idx     = oidx_q;

endmodule

// File: tb/tb_kmap_lut_seq.sv
// Directed plus randomized bench for kmap_lut_seq (N_IN=4, N_OUT=1).
// Expected values come from a per-entry table model updated only on full loads.
module tb_kmap_lut_seq;

  localparam int unsigned N_IN  = 4;
  localparam int unsigned N_OUT = 1;
  localparam int unsigned DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_bit = 1'b0;
  logic             cfg_ready;
  logic             cfg_done;
  logic             in_valid = 1'b0;
  logic [N_IN-1:0]  in_vec = '0;
  logic             in_ready;
  logic             out_valid;
  logic [N_OUT-1:0] out_vec;
  logic [N_IN-1:0]  out_idx;
  logic             sweep_start = 1'b0;
  logic             sweep_busy;
  logic             sweep_done;
  logic [N_IN:0]    sweep_count;

  int checks = 0;
  int errors = 0;

  // Reference: value of each table entry as last committed.
  logic model_tbl [DEPTH];

  always #5 clk = ~clk;

  kmap_lut_seq #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_bit     (cfg_bit),
    .cfg_ready   (cfg_ready),
    .cfg_done    (cfg_done),
    .in_valid    (in_valid),
    .in_vec      (in_vec),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_vec     (out_vec),
    .out_idx     (out_idx),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .sweep_count (sweep_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_count();
    int s = 0;
    for (int i = 0; i < DEPTH; i++) s += int'(model_tbl[i]);
    return s;
  endfunction

  task automatic load_bits(input logic [15:0] pat, input int first, input int last);
    int pulses = 0;
    for (int k = first; k <= last; k++) begin
      @(negedge clk);
      if (cfg_done) pulses++;
      cfg_valid = 1'b1;
      cfg_bit   = pat[k];
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      if (cfg_done) pulses++;
    end
    if (last == 15) begin
      for (int i = 0; i < DEPTH; i++) model_tbl[i] = pat[i];
      check("cfg_done_pulses", 32'(pulses), 32'd1);
    end else begin
      check("cfg_done_partial", 32'(pulses), 32'd0);
    end
  endtask

  task automatic eval_one(input logic [3:0] code, input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_vec   = code;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_idx"}, 32'(out_idx), 32'(code));
    check({tag, "_vec"}, 32'(out_vec), 32'(model_tbl[code]));
  endtask

  task automatic eval_burst(input int n);
    logic [3:0] prev = '0;
    bit have = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (have) begin
        check("burst_valid", 32'(out_valid), 32'd1);
        check("burst_idx", 32'(out_idx), 32'(prev));
        check("burst_vec", 32'(out_vec), 32'(model_tbl[prev]));
      end
      prev     = 4'($urandom_range(0, 15));
      in_valid = 1'b1;
      in_vec   = prev;
      have     = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("burst_last_idx", 32'(out_idx), 32'(prev));
    check("burst_last_vec", 32'(out_vec), 32'(model_tbl[prev]));
    @(negedge clk);
    check("burst_idle_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic run_sweep(input string tag, input int eval_code, input int abort_at,
                           input bit hold_cfg, input logic hold_bit);
    int n = 0;
    bit done = 1'b0;
    bit gap = 1'b0;
    int exp_cnt;
    exp_cnt = model_count();
    @(negedge clk);
    sweep_start = 1'b1;
    if (eval_code >= 0) begin
      in_valid = 1'b1;
      in_vec   = 4'(eval_code);
    end
    @(negedge clk);
    sweep_start = 1'b0;
    in_valid    = 1'b0;
    check({tag, "_busy"}, 32'(sweep_busy), 32'd1);
    check({tag, "_eval_first"}, 32'(out_valid), 32'(eval_code >= 0));
    if (eval_code >= 0) begin
      check({tag, "_eval_idx"}, 32'(out_idx), 32'(eval_code));
      check({tag, "_eval_vec"}, 32'(out_vec), 32'(model_tbl[eval_code]));
    end
    if (hold_cfg) begin
      cfg_valid = 1'b1;
      cfg_bit   = hold_bit;
    end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (hold_cfg && sweep_busy) check({tag, "_cfg_stall"}, 32'(cfg_ready), 32'd0);
      if (out_valid) begin
        if (abort_at >= 0 && int'(out_idx) == abort_at) begin
          rst_n     = 1'b0;
          cfg_valid = 1'b0;
          #1;
          check({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
          check({tag, "_rst_busy"}, 32'(sweep_busy), 32'd0);
          check({tag, "_rst_count"}, 32'(sweep_count), 32'd0);
          check({tag, "_rst_idx"}, 32'(out_idx), 32'd0);
          check({tag, "_rst_in_ready"}, 32'(in_ready), 32'd1);
          for (int i = 0; i < DEPTH; i++) model_tbl[i] = 1'b0;
          for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            check({tag, "_rst_no_done"}, 32'(sweep_done), 32'd0);
            check({tag, "_rst_no_cfg_done"}, 32'(cfg_done), 32'd0);
          end
          rst_n = 1'b1;
          return;
        end
        check({tag, "_idx"}, 32'(out_idx), 32'(n));
        check({tag, "_vec"}, 32'(out_vec), 32'(model_tbl[n % DEPTH]));
        n++;
      end else if (n > 0 && n < DEPTH) begin
        gap = 1'b1;
      end
      if (sweep_done) begin
        done      = 1'b1;
        cfg_valid = 1'b0;
        check({tag, "_done_busy"}, 32'(sweep_busy), 32'd0);
        check({tag, "_count"}, 32'(sweep_count), 32'(exp_cnt));
      end
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_outputs"}, 32'(n), 32'(DEPTH));
    check({tag, "_no_gap"}, 32'(gap), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(sweep_done), 32'd0);
    check({tag, "_count_held"}, 32'(sweep_count), 32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] old_tbl;
    logic [15:0] new_tbl;
    logic [15:0] rnd;

    for (int i = 0; i < DEPTH; i++) model_tbl[i] = 1'b0;

    // 1: reset state
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_vec", 32'(out_vec), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_cfg_done", 32'(cfg_done), 32'd0);
    check("rst_sweep_busy", 32'(sweep_busy), 32'd0);
    check("rst_sweep_done", 32'(sweep_done), 32'd0);
    check("rst_sweep_count", 32'(sweep_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    eval_one(4'hA, "rst_eval");

    // 2: XOR-4 table
    load_bits(16'h6996, 0, 15);
    eval_one(4'b0111, "xor_0111");
    eval_one(4'b0011, "xor_0011");

    // 3: sweep of XOR-4, then one with a coincident eval
    run_sweep("sw_xor", -1, -1, 1'b0, 1'b0);
    check("xor_count8", 32'(sweep_count), 32'd8);
    run_sweep("sw_xor_ev", 9, -1, 1'b0, 1'b0);

    // 4: full-width count and empty table
    load_bits(16'hFFFF, 0, 15);
    run_sweep("sw_ones", -1, -1, 1'b0, 1'b0);
    check("ones_count16", 32'(sweep_count), 32'd16);
    load_bits(16'h0000, 0, 15);
    run_sweep("sw_zero", -1, -1, 1'b0, 1'b0);

    // 5: partial load stalled by a sweep
    old_tbl = 16'($urandom);
    load_bits(old_tbl, 0, 15);
    new_tbl = ~old_tbl ^ 16'h1234;
    load_bits(new_tbl, 0, 6);
    run_sweep("sw_stall", -1, -1, 1'b1, ~new_tbl[7]);
    load_bits(new_tbl, 7, 15);
    run_sweep("sw_after", -1, -1, 1'b0, 1'b0);

    // Random tables with eval bursts and sweeps
    for (int t = 0; t < 3; t++) begin
      rnd = 16'($urandom);
      load_bits(rnd, 0, 15);
      eval_burst(8);
      run_sweep("sw_rand", int'($urandom_range(0, 15)), -1, 1'b0, 1'b0);
    end

    // 6: reset at sweep index 5, then restart
    rnd = 16'($urandom);
    load_bits(rnd, 0, 15);
    run_sweep("sw_abort", -1, 5, 1'b0, 1'b0);
    run_sweep("sw_restart", -1, -1, 1'b0, 1'b0);
    rnd = 16'($urandom);
    load_bits(rnd, 0, 15);
    run_sweep("sw_reload", -1, -1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
